// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU operand interface: opcodes,
// host-driver state encoding and the two-byte-result helper.
package alu_pkg;

  // Opcode carried on req_op / alu_op.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  // Host-driver sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BEAT_A  = 3'd1,
    ST_BEAT_B  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPT_LO = 3'd4,
    ST_RESP    = 3'd5
  } drv_state_t;

  // Mul and div return two result bytes (hi/rem first, then lo/quot).
  function automatic logic is_two_byte(input op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_host_driver.sv
// Purpose: turns one parallel (op, A, B) request into the ALU's two-beat operand
// sequence, collects the 1- or 2-byte result and returns it on a valid/ready port.
// Latency: accept->rsp_valid is 3 cycles (add/sub) or 4 (mul/div) plus ALU compute.
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready.
// Optional: ALU_HOST_DRIVER_TIMEOUT_EN adds a WAIT-state timeout (TIMEOUT_CYCLES).
module alu_host_driver
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic [1:0]  alu_op,
  output logic [7:0]  alu_in,
  output logic        alu_valid,
  input  logic [7:0]  alu_o,
  input  logic        alu_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err
);

  // The wait counter must be able to represent the timeout value.
  localparam bit CFG_OK = (TIMEOUT_CYCLES > 0) && (TIMEOUT_CYCLES < (1 << CNT_W));
  generate
    if (!CFG_OK) begin : g_bad_cnt_w
      $error("alu_host_driver: CNT_W cannot hold TIMEOUT_CYCLES");
    end
  endgenerate

  drv_state_t  state_q, state_d;
  op_t         op_q, op_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

`ifdef ALU_HOST_DRIVER_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  // Next-state, operand capture, result capture and pin drive.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
`ifdef ALU_HOST_DRIVER_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    req_ready  = 1'b0;
    alu_valid  = 1'b0;
    alu_in     = 8'h00;
    alu_op     = 2'b00;
    rsp_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Not ready while reset is held, even though the state reads IDLE.
        req_ready = !rst;
        if (req_valid) begin
          op_d    = op_t'(req_op);
          a_d     = req_a;
          b_d     = req_b;
          state_d = ST_BEAT_A;
        end
      end

      ST_BEAT_A: begin
        alu_valid = 1'b1;
        alu_in    = a_q;
        alu_op    = op_q;
        state_d   = ST_BEAT_B;
      end

      ST_BEAT_B: begin
        alu_in  = b_q;
        alu_op  = op_q;
`ifdef ALU_HOST_DRIVER_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        alu_in = b_q;
        alu_op = op_q;
        if (alu_ready) begin
          // A ready on the expiry cycle still takes the normal capture path.
          rsp_err_d = 1'b0;
          if (is_two_byte(op_q)) begin
            rsp_data_d = {alu_o, 8'h00};
            state_d    = ST_CAPT_LO;
          end else begin
            rsp_data_d = {8'h00, alu_o};
            state_d    = ST_RESP;
          end
        end
`ifdef ALU_HOST_DRIVER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = 16'hFFFF;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      ST_CAPT_LO: begin
        // The ALU must deliver the low byte back-to-back with the high byte.
        alu_in = b_q;
        alu_op = op_q;
        if (alu_ready) begin
          rsp_data_d[7:0] = alu_o;
        end else begin
          rsp_err_d = 1'b1;
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_err_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_ADD;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      rsp_data_q <= 16'h0000;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

`ifdef ALU_HOST_DRIVER_TIMEOUT_EN
  // Wait-cycle counter for the timeout abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_host_driver.sv
// Bench for alu_host_driver: behavioural serial-ALU responder plus a
// request-level reference (plain arithmetic) for results and latency.
module tb_alu_host_driver;

  localparam int TMO = 8;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [1:0]  alu_op;
  logic [7:0]  alu_in;
  logic        alu_valid;
  logic [7:0]  alu_o;
  logic        alu_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  // Expectations shared with the ALU responder.
  logic [1:0] exp_op;
  logic [7:0] exp_a;
  logic [7:0] exp_b;
  int         m_dly  = 1;
  int         m_mode = 0;   // 0 normal, 1 single ready pulse, 2 never ready

  alu_host_driver #(.TIMEOUT_CYCLES(TMO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_in(alu_in), .alu_valid(alu_valid),
    .alu_o(alu_o), .alu_ready(alu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // What the ALU should produce: {8'h00,byte} for add/sub, {hi,lo}/{rem,quot}.
  function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return {8'h00, 8'(a + b)};
      2'b01:   return {8'h00, 8'(a - b)};
      2'b10:   return 16'(a) * 16'(b);
      default: return {8'(a % b), 8'(a / b)};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural serial ALU: watches the two operand beats, then answers.
  initial begin : alu_model
    logic [7:0]  ma, mb;
    logic [1:0]  mop;
    logic [15:0] r;
    alu_ready = 1'b0;
    alu_o     = 8'h00;
    forever begin
      step();
      if (!rst && alu_valid) begin
        ma  = alu_in;
        mop = alu_op;
        chk("beatA_in", 32'(ma), 32'(exp_a));
        chk("beatA_op", 32'(mop), 32'(exp_op));
        step();
        chk("beatB_vld", 32'(alu_valid), 0);
        chk("beatB_in", 32'(alu_in), 32'(exp_b));
        chk("beatB_op", 32'(alu_op), 32'(exp_op));
        mb = alu_in;
        if (m_mode != 2) begin
          r = ref_result(mop, ma, mb);
          repeat (m_dly) step();
          alu_ready = 1'b1;
          if (mop[1]) begin
            alu_o = r[15:8];
            step();
            if (m_mode == 1) alu_ready = 1'b0;
            else alu_o = r[7:0];
          end else begin
            alu_o = r[7:0];
          end
          step();
          alu_ready = 1'b0;
          alu_o     = 8'h00;
        end
      end
    end
  end

  // Present one request; returns once it has been accepted (at the BEAT_A cycle).
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int dly, input int mode);
    int w;
    exp_op = op; exp_a = a; exp_b = b; m_dly = dly; m_mode = mode;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin step(); w++; end
    chk("req_rdy", 32'(req_ready), 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_txn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int dly, input int mode, input int hold, input bit pre);
    logic [15:0] want, d0;
    int lat;
    want = ref_result(op, a, b);
    rsp_ready = pre;
    issue(op, a, b, dly, mode);
    lat = 0;
    while (!rsp_valid && lat < 200) begin step(); lat++; end
    chk("rsp_vld", 32'(rsp_valid), 1);
    // 3 cycles minimum (4 for two-byte ops) plus (dly-1) cycles of ALU compute.
    chk("latency", 32'(lat), 32'(2 + dly + int'(op[1])));
    if (mode == 1 && op[1]) begin
      chk("proto_err", 32'(rsp_err), 1);
    end else begin
      chk("rsp_err", 32'(rsp_err), 0);
      chk("rsp_data", 32'(rsp_data), 32'(want));
    end
    d0 = rsp_data;
    for (int i = 0; i < hold && !pre; i++) begin
      step();
      chk("hold_vld", 32'(rsp_valid), 1);
      chk("hold_data", 32'(rsp_data), 32'(d0));
      chk("hold_req_rdy", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("taken_vld", 32'(rsp_valid), 0);
    chk("taken_err", 32'(rsp_err), 0);
    chk("idle_req_rdy", 32'(req_ready), 1);
  endtask

  initial begin : main
    int seen;
    logic [1:0] op;
    logic [7:0] a, b;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = 8'h00; req_b = 8'h00;
    rsp_ready = 1'b0;
    #2;
    chk("rst_req_rdy", 32'(req_ready), 0);
    chk("rst_alu_vld", 32'(alu_valid), 0);
    chk("rst_alu_in", 32'(alu_in), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_rsp_vld", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("post_rst_req_rdy", 32'(req_ready), 1);

    // Directed cases.
    do_txn(2'b00, 8'd10, 8'd5, 5, 0, 0, 1'b0);   // add -> 000F
    do_txn(2'b10, 8'd10, 8'd5, 2, 0, 0, 1'b0);   // mul -> 0032
    do_txn(2'b11, 8'd10, 8'd3, 1, 0, 4, 1'b0);   // div -> 0103, held 4 cycles
    do_txn(2'b10, 8'd7,  8'd9, 2, 1, 1, 1'b0);   // single ready pulse -> error
    do_txn(2'b01, 8'd3,  8'd9, 1, 0, 0, 1'b1);   // sub wraps, rsp_ready pre-high
    do_txn(2'b10, 8'hFF, 8'hFF, 1, 0, 0, 1'b1);  // max product, back-to-back

    // Randomised traffic.
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(1, 255));
      do_txn(op, a, b, $urandom_range(1, 6), 0, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    // ALU never answers.
`ifdef ALU_HOST_DRIVER_TIMEOUT_EN
    issue(2'b10, 8'd4, 8'd4, 1, 2);
    seen = 0;
    while (!rsp_valid && seen < 200) begin step(); seen++; end
    chk("tmo_latency", 32'(seen), 32'(2 + TMO));
    chk("tmo_err", 32'(rsp_err), 1);
    chk("tmo_data", 32'(rsp_data), 32'hFFFF);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    chk("tmo_taken", 32'(rsp_valid), 0);
    issue(2'b10, 8'd6, 8'd2, 1, 2);
    repeat (4) step();
`else
    issue(2'b10, 8'd6, 8'd2, 1, 2);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    chk("stuck_in_wait", 32'(seen), 0);
`endif
    chk("wait_alu_in", 32'(alu_in), 32'd2);
    chk("wait_alu_op", 32'(alu_op), 32'd2);

    // Reset in the middle of WAIT: outputs clear before the next clock edge.
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_req_rdy", 32'(req_ready), 0);
    chk("mid_rst_alu_in", 32'(alu_in), 0);
    chk("mid_rst_alu_op", 32'(alu_op), 0);
    chk("mid_rst_alu_vld", 32'(alu_valid), 0);
    chk("mid_rst_rsp_vld", 32'(rsp_valid), 0);
    chk("mid_rst_rsp_data", 32'(rsp_data), 0);
    chk("mid_rst_rsp_err", 32'(rsp_err), 0);
    step();
    rst = 1'b0;
    #1;
    chk("rel_rst_req_rdy", 32'(req_ready), 1);
    do_txn(2'b00, 8'd3, 8'd4, 1, 0, 0, 1'b0);    // fresh add -> 0007

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
